// File: rtl/avalon_mem_responder_pkg.sv
// Shared types for the Avalon-MM memory responder.
//   t_rd_req   : one queued read burst (line address, beat count)
//   t_wr_state : write-path burst tracking (start-of-packet / body)
//   t_rd_state : read engine state (idle / bursting)
//   LFSR_SEED  : reset value of the backpressure LFSR
//   lfsr_next  : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package avalon_mem_responder_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Queue fields are sized for the largest supported configuration; the
  // responder only uses the low MEM_ADDR_BITS / BURST_CNT_WIDTH bits.
  localparam int RQ_ADDR_W = 32;
  localparam int RQ_LEN_W  = 16;

  typedef enum logic {
    WR_SOP  = 1'b0,
    WR_BODY = 1'b1
  } t_wr_state;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } t_rd_state;

  typedef struct packed {
    logic [RQ_ADDR_W-1:0] addr;
    logic [RQ_LEN_W-1:0]  len;
  } t_rd_req;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/avalon_mem_responder_rd_fifo.sv
// Synchronous FIFO of queued read bursts with first-word fall-through.
//   clk, reset : clock, synchronous active-high reset (clears pointers/count)
//   push       : write push_data (ignored when full)
//   push_data  : read request to enqueue
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags; a simultaneous push and pop keeps the count
module avalon_mem_responder_rd_fifo
  import avalon_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  t_rd_req push_data,
  input  logic    pop,
  output t_rd_req pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  t_rd_req          store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder backed by an on-chip line array, standing in for a
// memory controller in loopback/simulation builds.
//   clk, reset          : clock, synchronous active-high reset
//   address, burstcount : burst start line and length (first beat only)
//   read, write         : request strobes (write wins if both set)
//   byteenable          : per-beat write byte mask
//   writedata           : write beat data
//   waitrequest         : request not accepted this cycle
//   readdata/valid      : in-order read response beats
//   stall_en            : enable pseudo-random backpressure
//   rd_beats, wr_beats  : free-running beat counters
//   err_zero_burst      : sticky flag, burstcount of 0 was accepted
module avalon_mem_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MEM_ADDR_BITS   = 10,
  parameter int RD_Q_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       read,
  input  logic                       write,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  input  logic [DATA_WIDTH-1:0]      writedata,
  output logic                       waitrequest,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  input  logic                       stall_en,
  output logic [31:0]                rd_beats,
  output logic [31:0]                wr_beats,
  output logic                       err_zero_burst
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int MEM_LINES = 1 << MEM_ADDR_BITS;
  localparam logic [MEM_ADDR_BITS-1:0]   ADDR_ONE = MEM_ADDR_BITS'(1);
  localparam logic [BURST_CNT_WIDTH-1:0] LEN_ONE  = BURST_CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [MEM_LINES];

  logic [15:0]                lfsr;
  logic                       stall;
  logic                       zero_burst;
  logic [BURST_CNT_WIDTH-1:0] bc_eff;
  logic                       wr_sop;
  logic                       wr_acc;
  logic                       rd_acc;
  logic                       rd_pending;

  t_wr_state                  wr_state, wr_state_nxt;
  logic [MEM_ADDR_BITS-1:0]   wr_addr, wr_addr_nxt, wr_beat_addr;
  logic [BURST_CNT_WIDTH-1:0] wr_left, wr_left_nxt;

  t_rd_state                  rd_state, rd_state_nxt;
  logic [MEM_ADDR_BITS-1:0]   rd_addr, rd_addr_nxt;
  logic [BURST_CNT_WIDTH-1:0] rd_left, rd_left_nxt;
  logic                       rd_issue;

  t_rd_req                    rdq_push_data;
  t_rd_req                    rdq_head;
  logic                       rdq_pop;
  logic                       rdq_full;
  logic                       rdq_empty;
  logic [MEM_ADDR_BITS-1:0]   head_addr;
  logic [BURST_CNT_WIDTH-1:0] head_len;

  logic                       unused_ok;

  assign unused_ok = ^{address[ADDR_WIDTH-1:MEM_ADDR_BITS],
                       rdq_head.addr[RQ_ADDR_W-1:MEM_ADDR_BITS],
                       rdq_head.len[RQ_LEN_W-1:BURST_CNT_WIDTH]};

  assign stall      = stall_en && (lfsr[1:0] == 2'b00);
  assign wr_sop     = (wr_state == WR_SOP);
  assign rd_pending = !rdq_empty || (rd_state == RD_BURST);

  // A write may only start once every earlier read has been issued, and a
  // read may not split a write burst; this keeps responses in request order.
  assign waitrequest = reset | stall | (read && rdq_full) | (read && !wr_sop)
                     | (write && wr_sop && rd_pending);

  assign wr_acc     = write && !waitrequest;
  assign rd_acc     = read && !write && !waitrequest;
  assign zero_burst = (burstcount == '0);
  assign bc_eff     = zero_burst ? LEN_ONE : burstcount;

  always_comb begin
    rdq_push_data      = '0;
    rdq_push_data.addr = RQ_ADDR_W'(address[MEM_ADDR_BITS-1:0]);
    rdq_push_data.len  = RQ_LEN_W'(bc_eff);
  end

  assign head_addr = rdq_head.addr[MEM_ADDR_BITS-1:0];
  assign head_len  = rdq_head.len[BURST_CNT_WIDTH-1:0];

  avalon_mem_responder_rd_fifo #(
    .DEPTH (RD_Q_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_acc),
    .push_data (rdq_push_data),
    .pop       (rdq_pop),
    .pop_data  (rdq_head),
    .full      (rdq_full),
    .empty     (rdq_empty)
  );

  // wr_addr holds the line of the next body beat; wr_left counts body beats
  // still to come, so a body beat accepted with wr_left==1 ends the burst.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_addr_nxt  = wr_addr;
    wr_left_nxt  = wr_left;
    wr_beat_addr = wr_addr;
    if (wr_acc) begin
      if (wr_sop) begin
        wr_beat_addr = address[MEM_ADDR_BITS-1:0];
        wr_addr_nxt  = address[MEM_ADDR_BITS-1:0] + ADDR_ONE;
        wr_left_nxt  = bc_eff - LEN_ONE;
        wr_state_nxt = (bc_eff == LEN_ONE) ? WR_SOP : WR_BODY;
      end else begin
        wr_addr_nxt  = wr_addr + ADDR_ONE;
        wr_left_nxt  = wr_left - LEN_ONE;
        wr_state_nxt = (wr_left == LEN_ONE) ? WR_SOP : WR_BODY;
      end
    end
  end

  // The last beat of a burst pops the next request in the same cycle so
  // consecutive bursts stream without a bubble.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_left_nxt  = rd_left;
    rd_issue     = 1'b0;
    rdq_pop      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (!rdq_empty) begin
          rdq_pop      = 1'b1;
          rd_addr_nxt  = head_addr;
          rd_left_nxt  = head_len;
          rd_state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        if (rd_left == LEN_ONE) begin
          if (!rdq_empty) begin
            rdq_pop     = 1'b1;
            rd_addr_nxt = head_addr;
            rd_left_nxt = head_len;
          end else begin
            rd_state_nxt = RD_IDLE;
          end
        end else begin
          rd_addr_nxt = rd_addr + ADDR_ONE;
          rd_left_nxt = rd_left - LEN_ONE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Stage p0: array read registered straight into the response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr           <= LFSR_SEED;
      wr_state       <= WR_SOP;
      rd_state       <= RD_IDLE;
      readdatavalid  <= 1'b0;
      readdata       <= '0;
      rd_beats       <= '0;
      wr_beats       <= '0;
      err_zero_burst <= 1'b0;
    end else begin
      lfsr          <= lfsr_next(lfsr);
      wr_state      <= wr_state_nxt;
      rd_state      <= rd_state_nxt;
      readdatavalid <= rd_issue;
      if (rd_issue) begin
        readdata <= mem[rd_addr];
        rd_beats <= rd_beats + 32'd1;
      end
      if (wr_acc) wr_beats <= wr_beats + 32'd1;
      if (((wr_acc && wr_sop) || rd_acc) && zero_burst) err_zero_burst <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr <= wr_addr_nxt;
    wr_left <= wr_left_nxt;
    rd_addr <= rd_addr_nxt;
    rd_left <= rd_left_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) mem[wr_beat_addr][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder: a line-array model is updated on
// every accepted write beat, and the expected beats of each read are queued
// at the read's acceptance and compared as readdatavalid beats arrive.
module tb_avalon_mem_responder;

  localparam int AW    = 27;
  localparam int DW    = 512;
  localparam int BW    = 7;
  localparam int BEW   = DW / 8;
  localparam int LINES = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  address;
  logic           read;
  logic           write;
  logic [BW-1:0]  burstcount;
  logic [BEW-1:0] byteenable;
  logic [DW-1:0]  writedata;
  logic           waitrequest;
  logic [DW-1:0]  readdata;
  logic           readdatavalid;
  logic           stall_en;
  logic [31:0]    rd_beats;
  logic [31:0]    wr_beats;
  logic           err_zero_burst;

  always #5 clk = ~clk;

  avalon_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .read           (read),
    .write          (write),
    .burstcount     (burstcount),
    .byteenable     (byteenable),
    .writedata      (writedata),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .readdatavalid  (readdatavalid),
    .stall_en       (stall_en),
    .rd_beats       (rd_beats),
    .wr_beats       (wr_beats),
    .err_zero_burst (err_zero_burst)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdv_seen = 0;
  int          wr_seen = 0;
  int          acc_cyc = 0;
  logic [DW-1:0] model [LINES];
  logic [DW-1:0] exp_q [$];
  int          rdv_cyc_q [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      rdv_seen++;
      rdv_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("rdv_unexpected", 1, 0);
      else check("rdata", readdata, exp_q.pop_front());
    end
  end

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_accept(output int waits);
    waits = 0;
    forever begin
      @(negedge clk);
      if (waitrequest === 1'b0) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        return;
      end
      waits++;
      if (waits > 3000) begin
        check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  task automatic wr_burst(input int addr, input int bc, input bit rnd,
                          input logic [DW-1:0] d, input logic [BEW-1:0] be, output int waits);
    int nb, w, line;
    logic [DW-1:0] dv;
    nb = (bc == 0) ? 1 : bc;
    waits = 0;
    for (int i = 0; i < nb; i++) begin
      dv = rnd ? rand_line() : d;
      write      = 1'b1;
      writedata  = dv;
      byteenable = be;
      // body beats carry junk address/burstcount: only the first beat counts
      address    = (i == 0) ? AW'(addr) : AW'($urandom);
      burstcount = (i == 0) ? BW'(bc) : BW'($urandom);
      wait_accept(w);
      waits += w;
      line = (addr + i) & (LINES - 1);
      for (int b = 0; b < BEW; b++) if (be[b]) model[line][b*8 +: 8] = dv[b*8 +: 8];
      wr_seen++;
    end
    write = 1'b0;
  endtask

  task automatic rd_burst(input int addr, input int bc, output int waits);
    int nb;
    read       = 1'b1;
    address    = AW'(addr);
    burstcount = BW'(bc);
    wait_accept(waits);
    read = 1'b0;
    nb = (bc == 0) ? 1 : bc;
    for (int i = 0; i < nb; i++) exp_q.push_back(model[(addr + i) & (LINES - 1)]);
  endtask

  task automatic wait_rdv();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (readdatavalid === 1'b1) return;
    end
    check("rdv_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", exp_q.size() == 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, lat, tw, b0, a;
    reset = 1'b1; read = 1'b0; write = 1'b0; stall_en = 1'b0;
    address = '0; burstcount = '0; byteenable = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitrequest", waitrequest, 1);
    check("rst_rdv", readdatavalid, 0);
    check("rst_readdata", readdata, 0);
    check("rst_rd_beats", rd_beats, 0);
    check("rst_wr_beats", wr_beats, 0);
    check("rst_err", err_zero_burst, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // fill the whole array so every later read has defined contents
    for (int k = 0; k < LINES/64; k++) wr_burst(k*64, 64, 1'b1, '0, '1, w);
    check("fill_wr_beats", wr_beats, wr_seen);

    // basic burst write then read with latency and contiguity
    wr_burst(16, 4, 1'b1, '0, '1, w);
    check("t1_wr_waits", w, 0);
    check("t1_wr_beats", wr_beats, wr_seen);
    rd_burst(16, 4, w);
    a = acc_cyc;
    wait_rdv();
    lat = cyc - a;
    check("t1_latency", lat, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_contig", readdatavalid, 1);
    end
    drain();
    check("t1_rd_beats", rd_beats, rdv_seen);

    // byte-lane masking
    wr_burst(5, 1, 1'b0, {DW{1'b1}}, '1, w);
    wr_burst(5, 1, 1'b0, '0, 64'h1, w);
    rd_burst(5, 1, w);
    wait_rdv();
    check("be_line5", readdata, {{(DW-8){1'b1}}, 8'h00});
    drain();

    // queue fills: six 8-beat reads back to back, 48 contiguous beats
    rdv_cyc_q.delete();
    tw = 0;
    for (int k = 0; k < 6; k++) begin
      rd_burst(100 + 8*k, 8, w);
      tw += w;
    end
    check("qfull_held", w > 0, 1);
    drain();
    check("qfull_beats", rdv_cyc_q.size(), 48);
    if (rdv_cyc_q.size() == 48) check("qfull_contig", rdv_cyc_q[47] - rdv_cyc_q[0], 47);

    // a write must not overtake an earlier read
    rd_burst(0, 8, w);
    wr_burst(0, 1, 1'b0, {BEW{8'hAA}}, '1, w);
    check("order_wr_held", w >= 8, 1);
    drain();
    rd_burst(0, 1, w);
    wait_rdv();
    check("order_new_data", readdata, {BEW{8'hAA}});
    drain();

    // zero burstcount is one beat and sets the sticky flag
    check("err_before", err_zero_burst, 0);
    b0 = rdv_seen;
    rd_burst(7, 0, w);
    drain();
    check("zero_one_beat", rdv_seen - b0, 1);
    check("err_after", err_zero_burst, 1);
    wr_burst(9, 0, 1'b1, '0, '1, w);
    rd_burst(9, 2, w);
    drain();

    // wrap across the top of the array
    wr_burst(1022, 4, 1'b1, '0, '1, w);
    rd_burst(1021, 6, w);
    drain();

    // random traffic under backpressure, including near-top addresses
    stall_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      int ad, bc;
      ad = ($urandom_range(0, 3) == 0) ? (LINES - $urandom_range(1, 8)) : $urandom_range(0, LINES - 1);
      ad = ad + ($urandom_range(0, 3) << 10);
      bc = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 0) wr_burst(ad, bc, 1'b1, '0, {$urandom, $urandom}, w);
      else rd_burst(ad, bc, w);
    end
    drain();
    check("rand_rd_beats", rd_beats, rdv_seen);
    check("rand_wr_beats", wr_beats, wr_seen);
    stall_en = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of a read burst
    b0 = rdv_seen;
    rd_burst(200, 8, w);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #2;
      if (rdv_seen - b0 >= 2) break;
    end
    check("mid_reached", rdv_seen - b0, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    rdv_seen = 0;
    wr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_rdv", readdatavalid, 0);
      check("mid_rst_waitreq", waitrequest, 1);
      @(posedge clk); #1;
    end
    check("mid_rst_rd_beats", rd_beats, 0);
    check("mid_rst_wr_beats", wr_beats, 0);
    check("mid_rst_err", err_zero_burst, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle_rdv", readdatavalid, 0);
    rd_burst(200, 8, w);
    drain();
    check("post_rst_rd_beats", rd_beats, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
